xdma_axil_csr_slave: RTL and testbench
======================================

XDMA_AXIL_CSR_SLAVE -- requirements
Module: xdma_axil_csr_slave

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h5844_4D41, the constant returned at offset 0x00.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, the s_axil address width; only bits [4:2] are decoded.
REQ-003 SHALL have port user_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port user_reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports s_axil_awaddr (in, ADDR_WIDTH), s_axil_awvalid (in, 1) and s_axil_awready (out, 1): the AXI4-Lite write-address channel.
REQ-006 SHALL have ports s_axil_wdata (in, 32), s_axil_wstrb (in, 4), s_axil_wvalid (in, 1) and s_axil_wready (out, 1): the write-data channel.
REQ-007 SHALL have ports s_axil_bresp (out, 2), s_axil_bvalid (out, 1) and s_axil_bready (in, 1): the write-response channel.
REQ-008 SHALL have ports s_axil_araddr (in, ADDR_WIDTH), s_axil_arvalid (in, 1) and s_axil_arready (out, 1): the read-address channel.
REQ-009 SHALL have ports s_axil_rdata (out, 32), s_axil_rresp (out, 2), s_axil_rvalid (out, 1) and s_axil_rready (in, 1): the read-data channel.
REQ-010 SHALL have ports usr_irq_req (out, 1) and usr_irq_ack (in, 1): the user-interrupt handshake towards the DMA core.
REQ-011 SHALL have port irq_event (in, 1): a single-cycle hardware event pulse that sets STATUS bit 1.

Function
REQ-012 SHALL implement this register map:
- 0x00 ID, read-only, reads ID_VALUE.
- 0x04 SCRATCH, read/write.
- 0x08 CTRL, read/write; bit0 = irq_en, bits [31:1] read 0.
- 0x0C STATUS, write-1-to-clear, bits [1:0].
- 0x10 TRIGGER, write-only; a write of bit0=1 sets STATUS[0]; reads 0.
- 0x14 CYCLES, read-only 32-bit free-running counter that wraps at 2^32.
REQ-013 SHALL treat offsets 0x18-0x1C as unmapped: a write has no effect, a read returns 0, and the response is SLVERR (2'b10); every other response is OKAY (2'b00).
REQ-014 SHALL run the write path as the state machine W_IDLE -> W_RESP -> W_IDLE, with one write outstanding at a time.
REQ-015 SHALL, in W_IDLE, assert awready and wready independently until each beat is captured; AW and W may arrive in either order or in the same cycle.
REQ-016 SHALL apply the register write in the cycle both beats are held, assert bvalid on the next edge, and stay in W_RESP until bvalid && bready.
REQ-017 SHALL deassert awready and wready while in W_RESP.
REQ-018 SHALL apply wstrb per byte to SCRATCH and CTRL; writes to STATUS and TRIGGER use only byte 0 and ignore wstrb[3:1].
REQ-019 SHALL run the read path as the state machine R_IDLE -> R_DATA: arready is high in R_IDLE, rvalid/rdata/rresp are registered one cycle after the AR handshake, and the path returns to R_IDLE on rvalid && rready.
REQ-020 SHALL keep the read and write paths independent, so they may complete in the same cycle.
REQ-021 SHALL keep bvalid, bresp, rvalid, rdata and rresp stable while the response is stalled.
REQ-022 SHALL apply STATUS precedence set-over-clear: if a W1C and a set event (irq_event or TRIGGER) hit the same bit in the same cycle, the bit ends at 1.
REQ-023 SHALL drive the interrupt state machine IRQ_IDLE -> IRQ_REQ -> IRQ_WAIT:
- IRQ_IDLE to IRQ_REQ when irq_en=1 and STATUS != 0.
- In IRQ_REQ, usr_irq_req=1; on usr_irq_ack=1, go to IRQ_WAIT and drop req on the next edge.
- IRQ_WAIT to IRQ_IDLE once STATUS == 0, or irq_en == 0.
REQ-024 SHALL not abort a pending IRQ_REQ when irq_en is cleared; it completes on ack.

Reset
REQ-025 SHALL, on assertion of user_reset, asynchronously drive:
- awready, wready, arready, bvalid, rvalid and usr_irq_req to 0;
- bresp, rresp and rdata to 0;
- SCRATCH, CTRL, STATUS and CYCLES to 0;
- all state machines to their IDLE state.
REQ-026 SHALL, on reset asserted mid-transaction, drop the in-flight transaction with no response; awready, wready and arready go to 1 on the first edge after release.

Verification
REQ-027 SHALL cover: W of 0xDEADBEEF to 0x04 with wstrb=4'b0011, AW two cycles after W -> bresp=OKAY, then read 0x04 returns 0x0000BEEF.
REQ-028 SHALL cover: read 0x1C -> rresp=2'b10 and rdata=0; write 0x18 -> bresp=2'b10 and no register changes.
REQ-029 SHALL cover: CTRL=1, then an irq_event pulse -> usr_irq_req rises; ack -> req falls; write 0x0C=0x2 -> STATUS=0; a further irq_event re-raises req.
REQ-030 SHALL cover: a W1C of STATUS[1] in the same cycle as irq_event -> STATUS[1] stays 1.
REQ-031 SHALL cover: bready held low for 5 cycles while an AR to 0x00 completes -> rdata=ID_VALUE is returned and bvalid is held stable throughout.
REQ-032 SHALL cover: user_reset asserted with rvalid=1 -> rvalid=0 immediately, and a subsequent read of 0x14 is smaller than the cycle count before reset.

Source files
------------

// File: rtl/xdma_axil_csr_slave_if.sv
// AXI4-Lite bus bundle between a DMA core (master) and the CSR block (slave).
//
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where VALID and READY are both high; once VALID is raised the sender holds
// VALID and its payload unchanged until that transfer, and READY may rise or
// fall freely without waiting for VALID.
interface xdma_axil_csr_slave_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] s_axil_awaddr;
  logic                  s_axil_awvalid;
  logic                  s_axil_awready;
  logic [31:0]           s_axil_wdata;
  logic [3:0]            s_axil_wstrb;
  logic                  s_axil_wvalid;
  logic                  s_axil_wready;
  logic [1:0]            s_axil_bresp;
  logic                  s_axil_bvalid;
  logic                  s_axil_bready;
  logic [ADDR_WIDTH-1:0] s_axil_araddr;
  logic                  s_axil_arvalid;
  logic                  s_axil_arready;
  logic [31:0]           s_axil_rdata;
  logic [1:0]            s_axil_rresp;
  logic                  s_axil_rvalid;
  logic                  s_axil_rready;

  modport slave (
    input  s_axil_awaddr, s_axil_awvalid,
    output s_axil_awready,
    input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
    output s_axil_wready,
    output s_axil_bresp, s_axil_bvalid,
    input  s_axil_bready,
    input  s_axil_araddr, s_axil_arvalid,
    output s_axil_arready,
    output s_axil_rdata, s_axil_rresp, s_axil_rvalid,
    input  s_axil_rready
  );

  modport master (
    output s_axil_awaddr, s_axil_awvalid,
    input  s_axil_awready,
    output s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
    input  s_axil_wready,
    input  s_axil_bresp, s_axil_bvalid,
    output s_axil_bready,
    output s_axil_araddr, s_axil_arvalid,
    input  s_axil_arready,
    input  s_axil_rdata, s_axil_rresp, s_axil_rvalid,
    output s_axil_rready
  );
endinterface

// File: rtl/xdma_axil_csr_slave.sv
// AXI4-Lite control/status register slave for the XDMA user side.
// Registers: ID, SCRATCH, CTRL (irq_en), STATUS (W1C, set-over-clear),
// TRIGGER (software event), CYCLES (free-running). Offsets 0x18/0x1C are
// unmapped and answer SLVERR. A three-state machine drives usr_irq_req.
module xdma_axil_csr_slave #(
  parameter logic [31:0] ID_VALUE   = 32'h5844_4D41,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                   user_clk,
  input  logic                   user_reset,
  xdma_axil_csr_slave_if.slave   s_axil,
  output logic                   usr_irq_req,
  input  logic                   usr_irq_ack,
  input  logic                   irq_event,
  output logic                   dbg_w_state,
  output logic                   dbg_r_state,
  output logic [1:0]             dbg_irq_state
);

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_WAIT = 2'd2
  } irq_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Register indices decoded from address bits [4:2].
  localparam logic [2:0] IDX_ID      = 3'd0;
  localparam logic [2:0] IDX_SCRATCH = 3'd1;
  localparam logic [2:0] IDX_CTRL    = 3'd2;
  localparam logic [2:0] IDX_STATUS  = 3'd3;
  localparam logic [2:0] IDX_TRIGGER = 3'd4;
  localparam logic [2:0] IDX_CYCLES  = 3'd5;

  // State and register flops.
  logic       rdy_en_q, rdy_en_d;
  w_state_e   w_state_q, w_state_d;
  logic       aw_held_q, aw_held_d;
  logic       w_held_q, w_held_d;
  logic [2:0] aw_idx_q, aw_idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic       bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;
  r_state_e   r_state_q, r_state_d;
  logic       rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;
  logic [31:0] scratch_q, scratch_d;
  logic       irq_en_q, irq_en_d;
  logic [1:0] status_q, status_d;
  logic [31:0] cycles_q, cycles_d;
  irq_state_e irq_state_q, irq_state_d;

  // Combinational helpers.
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [ADDR_WIDTH-1:0] araddr;
  logic        unused_addr_bits;
  logic        aw_fire, w_fire, ar_fire;
  logic        do_write;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_unmapped;
  logic [1:0]  status_clr, status_set;
  logic [2:0]  rd_idx;
  logic [31:0] rd_mux;
  logic        rd_err;

  assign awaddr = s_axil.s_axil_awaddr;
  assign araddr = s_axil.s_axil_araddr;
  // Only bits [4:2] select a register; the rest of the address is ignored.
  assign unused_addr_bits = ^{awaddr[ADDR_WIDTH-1:5], awaddr[1:0],
                              araddr[ADDR_WIDTH-1:5], araddr[1:0]};

  // Ready lines stay low through reset and the first edge after it.
  assign s_axil.s_axil_awready = rdy_en_q && (w_state_q == W_IDLE) && !aw_held_q;
  assign s_axil.s_axil_wready  = rdy_en_q && (w_state_q == W_IDLE) && !w_held_q;
  assign s_axil.s_axil_arready = rdy_en_q && (r_state_q == R_IDLE);
  assign s_axil.s_axil_bvalid  = bvalid_q;
  assign s_axil.s_axil_bresp   = bresp_q;
  assign s_axil.s_axil_rvalid  = rvalid_q;
  assign s_axil.s_axil_rdata   = rdata_q;
  assign s_axil.s_axil_rresp   = rresp_q;

  assign aw_fire = s_axil.s_axil_awvalid && s_axil.s_axil_awready;
  assign w_fire  = s_axil.s_axil_wvalid && s_axil.s_axil_wready;
  assign ar_fire = s_axil.s_axil_arvalid && s_axil.s_axil_arready;

  // A beat captured in an earlier cycle wins over the live bus value.
  assign wr_idx      = aw_held_q ? aw_idx_q : awaddr[4:2];
  assign wr_data     = w_held_q ? wdata_q : s_axil.s_axil_wdata;
  assign wr_strb     = w_held_q ? wstrb_q : s_axil.s_axil_wstrb;
  assign wr_unmapped = (wr_idx[2:1] == 2'b11);
  assign do_write    = (w_state_q == W_IDLE) && (aw_held_q || aw_fire) && (w_held_q || w_fire);

  assign rd_idx = araddr[4:2];

  assign usr_irq_req   = (irq_state_q == IRQ_REQ);
  assign dbg_w_state   = w_state_q;
  assign dbg_r_state   = r_state_q;
  assign dbg_irq_state = irq_state_q;

  // Write channel FSM: collect AW and W in any order, then hold the response.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          aw_idx_d  = awaddr[4:2];
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = s_axil.s_axil_wdata;
          wstrb_d  = s_axil.s_axil_wstrb;
        end
        if (do_write) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_unmapped ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axil.s_axil_bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Register file update; hardware/trigger sets override a W1C on the same bit.
  always_comb begin
    scratch_d  = scratch_q;
    irq_en_d   = irq_en_q;
    status_clr = 2'b00;
    status_set = {irq_event, 1'b0};
    cycles_d   = cycles_q + 32'd1;
    if (do_write) begin
      case (wr_idx)
        IDX_SCRATCH: begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) scratch_d[8*b +: 8] = wr_data[8*b +: 8];
          end
        end
        IDX_CTRL: begin
          if (wr_strb[0]) irq_en_d = wr_data[0];
        end
        IDX_STATUS: begin
          if (wr_strb[0]) status_clr = wr_data[1:0];
        end
        IDX_TRIGGER: begin
          if (wr_strb[0] && wr_data[0]) status_set[0] = 1'b1;
        end
        default: ;
      endcase
    end
    status_d = (status_q & ~status_clr) | status_set;
  end

  // Read data selection for the register addressed on AR.
  always_comb begin
    rd_mux = 32'd0;
    rd_err = 1'b0;
    case (rd_idx)
      IDX_ID:      rd_mux = ID_VALUE;
      IDX_SCRATCH: rd_mux = scratch_q;
      IDX_CTRL:    rd_mux = {31'd0, irq_en_q};
      IDX_STATUS:  rd_mux = {30'd0, status_q};
      IDX_TRIGGER: rd_mux = 32'd0;
      IDX_CYCLES:  rd_mux = cycles_q;
      default:     rd_err = 1'b1;
    endcase
  end

  // Read channel FSM: register the response one cycle after AR, hold until taken.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          rvalid_d  = 1'b1;
          rdata_d   = rd_mux;
          rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axil.s_axil_rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Interrupt FSM: a raised request is only withdrawn by an ack.
  always_comb begin
    irq_state_d = irq_state_q;
    case (irq_state_q)
      IRQ_IDLE: if (irq_en_q && (status_q != 2'b00)) irq_state_d = IRQ_REQ;
      IRQ_REQ:  if (usr_irq_ack) irq_state_d = IRQ_WAIT;
      IRQ_WAIT: if ((status_q == 2'b00) || !irq_en_q) irq_state_d = IRQ_IDLE;
      default:  irq_state_d = IRQ_IDLE;
    endcase
  end

  assign rdy_en_d = 1'b1;

  // All state and registers, cleared asynchronously by user_reset.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      rdy_en_q    <= 1'b0;
      w_state_q   <= W_IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      aw_idx_q    <= 3'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      r_state_q   <= R_IDLE;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'd0;
      rresp_q     <= 2'b00;
      scratch_q   <= 32'd0;
      irq_en_q    <= 1'b0;
      status_q    <= 2'b00;
      cycles_q    <= 32'd0;
      irq_state_q <= IRQ_IDLE;
    end else begin
      rdy_en_q    <= rdy_en_d;
      w_state_q   <= w_state_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      aw_idx_q    <= aw_idx_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      r_state_q   <= r_state_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      scratch_q   <= scratch_d;
      irq_en_q    <= irq_en_d;
      status_q    <= status_d;
      cycles_q    <= cycles_d;
      irq_state_q <= irq_state_d;
    end
  end

endmodule

// File: tb/tb_xdma_axil_csr_slave.sv
// Self-checking bench for xdma_axil_csr_slave: directed scenarios plus a
// randomized register-access run checked against a register-map model.
module tb_xdma_axil_csr_slave;

  localparam logic [31:0] ID_VALUE = 32'h5844_4D41;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xdma_axil_csr_slave_if #(.ADDR_WIDTH(32)) ifc ();
  logic       usr_irq_req;
  logic       usr_irq_ack;
  logic       irq_event;
  logic       dbg_w_state;
  logic       dbg_r_state;
  logic [1:0] dbg_irq_state;

  xdma_axil_csr_slave #(.ID_VALUE(ID_VALUE), .ADDR_WIDTH(32)) dut (
    .user_clk      (clk),
    .user_reset    (rst),
    .s_axil        (ifc),
    .usr_irq_req   (usr_irq_req),
    .usr_irq_ack   (usr_irq_ack),
    .irq_event     (irq_event),
    .dbg_w_state   (dbg_w_state),
    .dbg_r_state   (dbg_r_state),
    .dbg_irq_state (dbg_irq_state)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Register-map model.
  logic [31:0] m_scratch;
  logic        m_irq_en;
  logic [1:0]  m_status;
  logic [31:0] tb_cyc;

  // Edges seen since reset release; equals what CYCLES must hold.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= 32'd0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  function automatic void model_reset();
    m_scratch = 32'd0;
    m_irq_en  = 1'b0;
    m_status  = 2'b00;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb, input bit ev);
    logic [4:0] off;
    logic [1:0] resp;
    off  = addr[4:0] & 5'h1C;
    resp = 2'b00;
    case (off)
      5'h04: for (int b = 0; b < 4; b++) if (strb[b]) m_scratch[8*b +: 8] = data[8*b +: 8];
      5'h08: if (strb[0]) m_irq_en = data[0];
      5'h0C: if (strb[0]) m_status = m_status & ~data[1:0];
      5'h10: if (strb[0] && data[0]) m_status[0] = 1'b1;
      5'h18, 5'h1C: resp = 2'b10;
      default: ;
    endcase
    if (ev) m_status[1] = 1'b1;
    return resp;
  endfunction

  function automatic logic [1:0] model_read(input logic [31:0] addr, input logic [31:0] cyc,
                                            output logic [31:0] data);
    logic [4:0] off;
    off = addr[4:0] & 5'h1C;
    data = 32'd0;
    case (off)
      5'h00: data = ID_VALUE;
      5'h04: data = m_scratch;
      5'h08: data = {31'd0, m_irq_en};
      5'h0C: data = {30'd0, m_status};
      5'h14: data = cyc;
      5'h18, 5'h1C: return 2'b10;
      default: ;
    endcase
    return 2'b00;
  endfunction

  // Driver: one write with independent AW/W delays and a B stall.
  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_stall, input bit ev, output logic [1:0] resp);
    int k;
    bit aw_done;
    bit w_done;
    logic [1:0] held;
    k = 0; aw_done = 0; w_done = 0; resp = 2'bxx;
    ifc.s_axil_awaddr = addr;
    ifc.s_axil_wdata  = data;
    ifc.s_axil_wstrb  = strb;
    while (!(aw_done && w_done) && k < 40) begin
      @(negedge clk);
      ifc.s_axil_awvalid = !aw_done && (k >= aw_dly);
      ifc.s_axil_wvalid  = !w_done && (k >= w_dly);
      if (ifc.s_axil_awvalid && ifc.s_axil_awready) aw_done = 1;
      if (ifc.s_axil_wvalid && ifc.s_axil_wready) w_done = 1;
      if (ev && aw_done && w_done) irq_event = 1'b1;
      k++;
    end
    @(negedge clk);
    ifc.s_axil_awvalid = 1'b0;
    ifc.s_axil_wvalid  = 1'b0;
    irq_event = 1'b0;
    if (!(aw_done && w_done)) begin
      n_cmp++; n_mis++;
      $display("FAIL wr_accept_timeout got aw=%0d w=%0d want both accepted", aw_done, w_done);
      return;
    end
    held = ifc.s_axil_bresp;
    for (int s = 0; s < b_stall; s++) begin
      n_cmp++;
      if (ifc.s_axil_bvalid !== 1'b1 || ifc.s_axil_bresp !== held) begin
        n_mis++;
        $display("FAIL b_stall_stable got bvalid=%b bresp=%b want bvalid=1 bresp=%b",
                 ifc.s_axil_bvalid, ifc.s_axil_bresp, held);
      end
      @(negedge clk);
    end
    ifc.s_axil_bready = 1'b1;
    k = 0;
    while (ifc.s_axil_bvalid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (ifc.s_axil_bvalid !== 1'b1) begin
      n_cmp++; n_mis++;
      $display("FAIL b_timeout got bvalid=%b want 1", ifc.s_axil_bvalid);
    end else begin
      resp = ifc.s_axil_bresp;
    end
    @(negedge clk);
    ifc.s_axil_bready = 1'b0;
  endtask

  // Driver: one read with AR delay and an R stall; reports the cycle count at AR.
  task automatic axil_read(input logic [31:0] addr, input int ar_dly, input int r_stall,
                           output logic [31:0] data, output logic [1:0] resp,
                           output logic [31:0] cyc_at_ar);
    int k;
    bit ar_done;
    logic [31:0] hd;
    logic [1:0] hr;
    k = 0; ar_done = 0; data = 'x; resp = 2'bxx; cyc_at_ar = 'x;
    ifc.s_axil_araddr = addr;
    while (!ar_done && k < 40) begin
      @(negedge clk);
      ifc.s_axil_arvalid = (k >= ar_dly);
      if (ifc.s_axil_arvalid && ifc.s_axil_arready) begin
        ar_done = 1;
        cyc_at_ar = tb_cyc;
      end
      k++;
    end
    @(negedge clk);
    ifc.s_axil_arvalid = 1'b0;
    if (!ar_done) begin
      n_cmp++; n_mis++;
      $display("FAIL ar_timeout got arready=%b want 1", ifc.s_axil_arready);
      return;
    end
    hd = ifc.s_axil_rdata;
    hr = ifc.s_axil_rresp;
    for (int s = 0; s < r_stall; s++) begin
      n_cmp++;
      if (ifc.s_axil_rvalid !== 1'b1 || ifc.s_axil_rdata !== hd || ifc.s_axil_rresp !== hr) begin
        n_mis++;
        $display("FAIL r_stall_stable got rvalid=%b rdata=%h rresp=%b want 1 %h %b",
                 ifc.s_axil_rvalid, ifc.s_axil_rdata, ifc.s_axil_rresp, hd, hr);
      end
      @(negedge clk);
    end
    ifc.s_axil_rready = 1'b1;
    k = 0;
    while (ifc.s_axil_rvalid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (ifc.s_axil_rvalid !== 1'b1) begin
      n_cmp++; n_mis++;
      $display("FAIL r_timeout got rvalid=%b want 1", ifc.s_axil_rvalid);
    end else begin
      data = ifc.s_axil_rdata;
      resp = ifc.s_axil_rresp;
    end
    @(negedge clk);
    ifc.s_axil_rready = 1'b0;
  endtask

  task automatic pulse_event();
    @(negedge clk);
    irq_event = 1'b1;
    m_status[1] = 1'b1;
    @(negedge clk);
    irq_event = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ifc.s_axil_awready, ifc.s_axil_wready, ifc.s_axil_arready, ifc.s_axil_bvalid,
         ifc.s_axil_rvalid, usr_irq_req} !== 6'b0) begin
      n_mis++;
      $display("FAIL reset_ctrl got %b want 000000", {ifc.s_axil_awready, ifc.s_axil_wready,
               ifc.s_axil_arready, ifc.s_axil_bvalid, ifc.s_axil_rvalid, usr_irq_req});
    end
    n_cmp++;
    if ({ifc.s_axil_bresp, ifc.s_axil_rresp, ifc.s_axil_rdata} !== 36'd0) begin
      n_mis++;
      $display("FAIL reset_data got bresp=%b rresp=%b rdata=%h want 0", ifc.s_axil_bresp,
               ifc.s_axil_rresp, ifc.s_axil_rdata);
    end
    n_cmp++;
    if ({dbg_w_state, dbg_r_state, dbg_irq_state} !== 4'd0) begin
      n_mis++;
      $display("FAIL reset_states got %b want 0000", {dbg_w_state, dbg_r_state, dbg_irq_state});
    end
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ifc.s_axil_awready, ifc.s_axil_wready, ifc.s_axil_arready} !== 3'b111) begin
      n_mis++;
      $display("FAIL ready_after_reset got %b want 111",
               {ifc.s_axil_awready, ifc.s_axil_wready, ifc.s_axil_arready});
    end
  endtask

  task automatic test_scratch_strobe();
    logic [1:0] r;
    logic [1:0] er;
    logic [31:0] d;
    logic [31:0] ed;
    logic [31:0] c;
    er = model_write(32'h04, 32'hDEAD_BEEF, 4'b0011, 0);
    axil_write(32'h04, 32'hDEAD_BEEF, 4'b0011, 2, 0, 0, 0, r);
    n_cmp++;
    if (r !== er) begin
      n_mis++; $display("FAIL strobe_bresp got %b want %b", r, er);
    end
    axil_read(32'h04, 0, 0, d, r, c);
    er = model_read(32'h04, c, ed);
    n_cmp++;
    if (d !== ed || r !== er) begin
      n_mis++; $display("FAIL strobe_read got %h/%b want %h/%b", d, r, ed, er);
    end
    n_cmp++;
    if (d !== 32'h0000_BEEF) begin
      n_mis++; $display("FAIL strobe_value got %h want 0000beef", d);
    end
  endtask

  task automatic test_unmapped();
    logic [1:0] r;
    logic [1:0] er;
    logic [31:0] d;
    logic [31:0] ed;
    logic [31:0] c;
    logic [31:0] a;
    axil_read(32'h1C, 0, 0, d, r, c);
    n_cmp++;
    if (r !== 2'b10 || d !== 32'd0) begin
      n_mis++; $display("FAIL unmapped_read got %h/%b want 0/10", d, r);
    end
    er = model_write(32'h18, 32'hFFFF_FFFF, 4'hF, 0);
    axil_write(32'h18, 32'hFFFF_FFFF, 4'hF, 0, 1, 0, 0, r);
    n_cmp++;
    if (r !== er) begin
      n_mis++; $display("FAIL unmapped_bresp got %b want %b", r, er);
    end
    for (int i = 0; i < 4; i++) begin
      a = 32'(4 * i + 4);
      axil_read(a, 0, 0, d, r, c);
      er = model_read(a, c, ed);
      n_cmp++;
      if (d !== ed || r !== er) begin
        n_mis++; $display("FAIL unmapped_side_effect addr=%h got %h/%b want %h/%b", a, d, r, ed, er);
      end
    end
  endtask

  task automatic test_irq();
    logic [1:0] r;
    logic [1:0] er;
    logic [31:0] d;
    logic [31:0] ed;
    logic [31:0] c;
    int k;
    er = model_write(32'h08, 32'h1, 4'hF, 0);
    axil_write(32'h08, 32'h1, 4'hF, 0, 0, 0, 0, r);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (usr_irq_req !== 1'b0) begin
      n_mis++; $display("FAIL irq_quiet got %b want 0", usr_irq_req);
    end
    pulse_event();
    k = 0;
    while (usr_irq_req !== 1'b1 && k < 6) begin @(negedge clk); k++; end
    n_cmp++;
    if (usr_irq_req !== 1'b1) begin
      n_mis++; $display("FAIL irq_raise got %b want 1", usr_irq_req);
    end
    usr_irq_ack = 1'b1;
    @(negedge clk);
    usr_irq_ack = 1'b0;
    n_cmp++;
    if (usr_irq_req !== 1'b0) begin
      n_mis++; $display("FAIL irq_ack_drop got %b want 0", usr_irq_req);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (usr_irq_req !== 1'b0) begin
      n_mis++; $display("FAIL irq_wait_low got %b want 0", usr_irq_req);
    end
    er = model_write(32'h0C, 32'h2, 4'hF, 0);
    axil_write(32'h0C, 32'h2, 4'hF, 0, 0, 0, 0, r);
    axil_read(32'h0C, 0, 0, d, r, c);
    er = model_read(32'h0C, c, ed);
    n_cmp++;
    if (d !== ed || d !== 32'd0) begin
      n_mis++; $display("FAIL irq_status_clear got %h want %h", d, ed);
    end
    pulse_event();
    k = 0;
    while (usr_irq_req !== 1'b1 && k < 6) begin @(negedge clk); k++; end
    n_cmp++;
    if (usr_irq_req !== 1'b1) begin
      n_mis++; $display("FAIL irq_reraise got %b want 1", usr_irq_req);
    end
    er = model_write(32'h08, 32'h0, 4'hF, 0);
    axil_write(32'h08, 32'h0, 4'hF, 0, 0, 0, 0, r);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (usr_irq_req !== 1'b1) begin
      n_mis++; $display("FAIL irq_hold_without_en got %b want 1", usr_irq_req);
    end
    usr_irq_ack = 1'b1;
    @(negedge clk);
    usr_irq_ack = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (usr_irq_req !== 1'b0) begin
      n_mis++; $display("FAIL irq_ack_without_en got %b want 0", usr_irq_req);
    end
    er = model_write(32'h0C, 32'h3, 4'hF, 0);
    axil_write(32'h0C, 32'h3, 4'hF, 0, 0, 0, 0, r);
  endtask

  task automatic test_set_over_clear();
    logic [1:0] r;
    logic [1:0] er;
    logic [31:0] d;
    logic [31:0] ed;
    logic [31:0] c;
    pulse_event();
    er = model_write(32'h0C, 32'h2, 4'h1, 1);
    axil_write(32'h0C, 32'h2, 4'h1, 1, 0, 0, 1, r);
    axil_read(32'h0C, 0, 0, d, r, c);
    er = model_read(32'h0C, c, ed);
    n_cmp++;
    if (d !== ed || d[1] !== 1'b1) begin
      n_mis++; $display("FAIL set_over_clear got %h want %h", d, ed);
    end
    er = model_write(32'h10, 32'h1, 4'h1, 0);
    axil_write(32'h10, 32'h1, 4'h1, 0, 0, 0, 0, r);
    er = model_write(32'h0C, 32'h2, 4'hE, 0);
    axil_write(32'h0C, 32'h2, 4'hE, 0, 0, 0, 0, r);
    axil_read(32'h0C, 0, 0, d, r, c);
    er = model_read(32'h0C, c, ed);
    n_cmp++;
    if (d !== ed) begin
      n_mis++; $display("FAIL status_strobe_ignored got %h want %h", d, ed);
    end
    er = model_write(32'h0C, 32'h3, 4'h1, 0);
    axil_write(32'h0C, 32'h3, 4'h1, 0, 0, 0, 0, r);
  endtask

  task automatic test_stall();
    logic [1:0] wr;
    logic [1:0] rr;
    logic [1:0] er;
    logic [31:0] d;
    logic [31:0] c;
    logic [31:0] wd;
    time t_w;
    time t_r;
    wd = $urandom();
    fork
      begin
        axil_write(32'h04, wd, 4'hF, 0, 0, 5, 0, wr);
        t_w = $time;
      end
      begin
        axil_read(32'h00, 1, 0, d, rr, c);
        t_r = $time;
      end
    join
    er = model_write(32'h04, wd, 4'hF, 0);
    n_cmp++;
    if (d !== ID_VALUE || rr !== 2'b00) begin
      n_mis++; $display("FAIL stall_id_read got %h/%b want %h/00", d, rr, ID_VALUE);
    end
    n_cmp++;
    if (wr !== er) begin
      n_mis++; $display("FAIL stall_bresp got %b want %b", wr, er);
    end
    n_cmp++;
    if (!(t_r < t_w)) begin
      n_mis++; $display("FAIL stall_read_first got read@%0t write@%0t want read earlier", t_r, t_w);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] wr;
    logic [1:0] rr;
    logic [1:0] er;
    logic [31:0] d;
    logic [31:0] ed;
    logic [31:0] c;
    logic [31:0] wd;
    time t_w;
    time t_r;
    for (int i = 0; i < 3; i++) begin
      wd = $urandom();
      er = model_read(32'h08, 0, ed);
      fork
        begin
          axil_write(32'h04, wd, 4'hF, 0, 0, 0, 0, wr);
          t_w = $time;
        end
        begin
          axil_read(32'h08, 0, 0, d, rr, c);
          t_r = $time;
        end
      join
      n_cmp++;
      if (d !== ed || rr !== er) begin
        n_mis++; $display("FAIL b2b_read got %h/%b want %h/%b", d, rr, ed, er);
      end
      er = model_write(32'h04, wd, 4'hF, 0);
      n_cmp++;
      if (wr !== er || t_w != t_r) begin
        n_mis++; $display("FAIL b2b_same_cycle got bresp=%b tw=%0t tr=%0t want %b equal", wr, t_w, t_r, er);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] r;
    logic [1:0] er;
    logic [31:0] d;
    logic [31:0] ed;
    logic [31:0] c;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0] st;
    for (int i = 0; i < 60; i++) begin
      a = $urandom();
      a[4:2] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom();
        st = 4'($urandom_range(0, 15));
        er = model_write(a, wd, st, 0);
        axil_write(a, wd, st, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 0, r);
        n_cmp++;
        if (r !== er) begin
          n_mis++; $display("FAIL rand_bresp addr=%h got %b want %b", a, r, er);
        end
      end else begin
        axil_read(a, $urandom_range(0, 3), $urandom_range(0, 3), d, r, c);
        er = model_read(a, c, ed);
        n_cmp++;
        if (d !== ed || r !== er) begin
          n_mis++; $display("FAIL rand_read addr=%h got %h/%b want %h/%b", a, d, r, ed, er);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pre;
    logic [31:0] d;
    logic [31:0] ed;
    logic [31:0] c;
    logic [1:0] r;
    logic [1:0] er;
    repeat (20) @(negedge clk);
    ifc.s_axil_araddr  = 32'h00;
    ifc.s_axil_arvalid = 1'b1;
    ifc.s_axil_awaddr  = 32'h04;
    ifc.s_axil_awvalid = 1'b1;
    @(negedge clk);
    ifc.s_axil_arvalid = 1'b0;
    ifc.s_axil_awvalid = 1'b0;
    n_cmp++;
    if (ifc.s_axil_rvalid !== 1'b1) begin
      n_mis++; $display("FAIL mid_rvalid_up got %b want 1", ifc.s_axil_rvalid);
    end
    pre = tb_cyc;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ifc.s_axil_rvalid, ifc.s_axil_bvalid, ifc.s_axil_arready, ifc.s_axil_awready} !== 4'b0 ||
        ifc.s_axil_rdata !== 32'd0) begin
      n_mis++;
      $display("FAIL mid_reset_async got rvalid=%b bvalid=%b arready=%b awready=%b rdata=%h want 0",
               ifc.s_axil_rvalid, ifc.s_axil_bvalid, ifc.s_axil_arready, ifc.s_axil_awready,
               ifc.s_axil_rdata);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ifc.s_axil_awready, ifc.s_axil_wready, ifc.s_axil_arready} !== 3'b111) begin
      n_mis++;
      $display("FAIL mid_ready_release got %b want 111",
               {ifc.s_axil_awready, ifc.s_axil_wready, ifc.s_axil_arready});
    end
    axil_read(32'h14, 0, 0, d, r, c);
    er = model_read(32'h14, c, ed);
    n_cmp++;
    if (d !== ed || r !== er || !(d < pre)) begin
      n_mis++; $display("FAIL mid_cycles got %h want %h (below %h)", d, ed, pre);
    end
    for (int i = 1; i < 4; i++) begin
      axil_read(32'(4 * i), 0, 0, d, r, c);
      er = model_read(32'(4 * i), c, ed);
      n_cmp++;
      if (d !== ed || r !== er) begin
        n_mis++; $display("FAIL mid_regs_cleared off=%0d got %h want %h", 4 * i, d, ed);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    usr_irq_ack = 1'b0;
    irq_event = 1'b0;
    ifc.s_axil_awaddr = '0;
    ifc.s_axil_awvalid = 1'b0;
    ifc.s_axil_wdata = '0;
    ifc.s_axil_wstrb = '0;
    ifc.s_axil_wvalid = 1'b0;
    ifc.s_axil_bready = 1'b0;
    ifc.s_axil_araddr = '0;
    ifc.s_axil_arvalid = 1'b0;
    ifc.s_axil_rready = 1'b0;
    model_reset();
    test_reset();
    test_scratch_strobe();
    test_unmapped();
    test_irq();
    test_set_over_clear();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
